// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - shared constants and helpers for the cube frame arbiter
package cube_pkg;
  localparam int SIDE        = 8;
  localparam int CUBE_BITS   = SIDE * SIDE * SIDE;
  localparam int DEFAULT_SRC = 0;

  function automatic int sel_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Bit offset of source i inside a flattened multi-source frame bus.
  function automatic int slice_of(input int i, input int bits = CUBE_BITS);
    return i * bits;
  endfunction
endpackage

// File: rtl/cube_watchdog.sv
// rtl/cube_watchdog.sv - silence counter; expired marks the last quiet cycle before fallback
module cube_watchdog #(
  parameter int TIMEOUT = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || clear) begin
      count_d = '0;
    end else if (count_q != TOP) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (TIMEOUT > 0) && enable && !clear && (count_q == LAST);
endmodule

// File: rtl/cube_frame_arbiter.sv
// rtl/cube_frame_arbiter.sv - selects one of NUM_SRC frame sources, double-buffered,
// swapping only at end-of-cube so the display never tears
module cube_frame_arbiter
  import cube_pkg::sel_width, cube_pkg::slice_of, cube_pkg::DEFAULT_SRC;
#(
  parameter int SIDE    = 8,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = sel_width(NUM_SRC),
  parameter int TIMEOUT = 100_000_000,
  parameter int CNT_W   = 16,
  localparam int CUBE_BITS = SIDE * SIDE * SIDE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             mode_sel,
  input  logic [NUM_SRC*CUBE_BITS-1:0] src_frame_flat,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic                         scan_done,
  output logic [NUM_SRC-1:0]           src_en,
  output logic [CUBE_BITS-1:0]         frame_cube_flat,
  output logic [SEL_W-1:0]             active_src,
  output logic                         fallback,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic                         frame_dropped
);
  localparam logic [SEL_W-1:0] DEF = SEL_W'(DEFAULT_SRC);

  logic [SEL_W-1:0]     req, req_q, req_d, active_q, active_d, cap_src;
  logic                 fallback_q, fallback_d, pending_q, pending_d, drop_q, drop_d;
  logic [CUBE_BITS-1:0] shadow_q, shadow_d, frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 change, swap, capture, req_valid, wd_expired;

  assign req       = (int'(mode_sel) < NUM_SRC) ? mode_sel : DEF;
  assign change    = (req != req_q);
  assign req_valid = src_valid[req];
  assign swap      = scan_done && pending_q;

  cube_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (req != DEF),
    .clear   (change || req_valid),
    .expired (wd_expired)
  );

  always_comb begin
    req_d      = req;
    fallback_d = fallback_q;
    active_d   = active_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    drop_d     = 1'b0;
    capture    = 1'b0;
    cap_src    = active_q;

    if (swap) begin
      frame_d   = shadow_q;
      cnt_d     = cnt_q + 1'b1;
      pending_d = 1'b0;
    end

    if (change) begin
      // Old-source frames are abandoned; the display keeps its frame until the new source delivers.
      pending_d = 1'b0;
      if (req == DEF) fallback_d = 1'b0;
      active_d = fallback_d ? DEF : req;
    end else begin
      if (fallback_q && req_valid) begin
        fallback_d = 1'b0;
        active_d   = req;
        capture    = 1'b1;
        cap_src    = req;
      end else if (src_valid[active_q]) begin
        capture = 1'b1;
      end else if (wd_expired && !fallback_q) begin
        fallback_d = 1'b1;
        active_d   = DEF;
      end

      if (capture) begin
        shadow_d  = src_frame_flat[slice_of(int'(cap_src), CUBE_BITS) +: CUBE_BITS];
        drop_d    = pending_q && !swap;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= DEF;
      fallback_q <= 1'b0;
      active_q   <= DEF;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      frame_q    <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      req_q      <= req_d;
      fallback_q <= fallback_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
    end
  end

  // In fallback the requested source stays powered so it can reclaim the display.
  assign src_en = (NUM_SRC'(1) << active_q) | (fallback_q ? (NUM_SRC'(1) << req_q) : '0);

  assign frame_cube_flat = frame_q;
  assign active_src      = active_q;
  assign fallback        = fallback_q;
  assign frame_cnt       = cnt_q;
  assign frame_dropped   = drop_q;
endmodule
